uart_rx: RTL

UART receiver that is the peer of the existing UART transmitter. It recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the serial line and presents each byte with a one-cycle done strobe. It uses the same runtime-programmable CLKS_PER_BIT divisor as the transmitter, so one baud setting serves both directions. It sits between the pad/loopback serial input and the UART register/FIFO logic.

---
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling on a runtime CLKS_PER_BIT divisor.
// Define UART_RX_MAJORITY_EN to vote every sample over the last three synchronized line values.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_en,
  input  logic        rx_i,
  input  logic [15:0] CLKS_PER_BIT,
  output logic [7:0]  o_RX_Byte,
  output logic        o_RX_Done,
  output logic        o_frame_err,
  output logic        o_RX_Active
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rx_s;
  logic                   w_samp;
  logic [15:0]            r_cnt;
  logic [15:0]            w_last;
  logic [15:0]            w_half;
  logic                   w_at_half;
  logic                   w_at_last;
  logic [2:0]             r_idx;
  logic [7:0]             r_shift;
  logic [7:0]             r_byte;
  logic                   r_done;
  logic                   r_err;
  logic                   w_done_set;
  logic                   w_err_set;
  logic                   w_active;

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign w_rx_s = r_sync[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rx_s};
    end
  end

  assign w_samp = (w_rx_s & r_hist[0]) | (w_rx_s & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
  assign w_samp = w_rx_s;
`endif

  assign w_last    = CLKS_PER_BIT - 16'd1;
  assign w_half    = w_last >> 1;
  assign w_at_half = (r_cnt == w_half);
  assign w_at_last = (r_cnt == w_last);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (rx_en && !w_rx_s) begin
          w_next = S_START;
        end
      end
      S_START: begin
        if (w_at_half) begin
          w_next = w_samp ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_at_last && (r_idx == 3'd7)) begin
          w_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_at_last) begin
          w_next = S_CLEANUP;
        end
      end
      // A held-low line (break) must go high before the receiver re-arms.
      S_CLEANUP: begin
        if (w_rx_s) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_active   = 1'b0;
    w_done_set = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      S_START: w_active = 1'b1;
      S_DATA:  w_active = 1'b1;
      S_STOP: begin
        w_active   = 1'b1;
        w_done_set = w_at_last & w_samp;
        w_err_set  = w_at_last & ~w_samp;
      end
      default: w_active = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= 16'd0;
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
    end else begin
      case (r_state)
        S_START: begin
          r_cnt <= w_at_half ? 16'd0 : r_cnt + 16'd1;
        end
        S_DATA: begin
          if (w_at_last) begin
            r_cnt          <= 16'd0;
            r_shift[r_idx] <= w_samp;
            r_idx          <= (r_idx == 3'd7) ? 3'd0 : r_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_STOP: begin
          r_cnt <= w_at_last ? 16'd0 : r_cnt + 16'd1;
        end
        default: begin
          r_cnt <= 16'd0;
          r_idx <= 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_byte <= 8'd0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_done_set;
      r_err  <= w_err_set;
      if (w_done_set) begin
        r_byte <= r_shift;
      end
    end
  end

  assign o_RX_Byte   = r_byte;
  assign o_RX_Done   = r_done;
  assign o_frame_err = r_err;
  assign o_RX_Active = w_active;

endmodule
